// File: rtl/core_pkg.sv
// Shared constants and types for the core front end: opcode field, NOP word,
// PC increment, fetch FSM encoding and the IF/ID register layout.
package core_pkg;

  localparam logic [5:0]  OPC_HALT = 6'h0A;
  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HALT_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_NOP = '{instr: NOP_WORD, pc: 32'h0, valid: 1'b0};

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, loads IF/ID, handles stalls,
// taken-branch redirect/squash, and HALT detection followed by a drain window.
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter logic [5:0]  HALT_OPC     = OPC_HALT,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  output logic [31:0] pc_po,
  input  logic [31:0] instruction_pi,
  input  logic        stall_pi,
  input  logic        branch_taken_pi,
  input  logic [31:0] branch_target_pi,
  output logic [31:0] if_id_instr_po,
  output logic [31:0] if_id_pc_po,
  output logic        if_id_valid_po,
  output logic        halted_po,
  output logic [15:0] fetch_count_po
);

  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

  logic [1:0]  state;
  logic [31:0] pc;
  if_id_t      if_id;
  logic        halted;
  logic [15:0] fetch_count;
  logic [7:0]  drain;

  logic        is_halt;
  logic        redirect;
  logic        fetch;
  logic [31:0] target;

  assign is_halt  = (opcode_of(instruction_pi) == HALT_OPC);
  // A resolved branch overrides a stall, but a halted core ignores everything.
  assign redirect = branch_taken_pi && (state != ST_HALTED);
  assign fetch    = !redirect && !stall_pi && (state == ST_RUN);
  assign target   = {branch_target_pi[31:2], 2'b00};

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state  <= ST_RUN;
      pc     <= RESET_PC;
      if_id  <= IF_ID_NOP;
      halted <= 1'b0;
      drain  <= '0;
    end else if (redirect) begin
      state <= ST_RUN;
      pc    <= target;
      if_id <= IF_ID_NOP;
      drain <= '0;
    end else if (!stall_pi) begin
      case (state)
        ST_RUN: begin
          if_id <= '{instr: instruction_pi, pc: pc, valid: 1'b1};
          if (is_halt) begin
            state <= ST_HALT_WAIT;
            drain <= DRAIN_INIT;
          end else begin
            pc <= pc + PC_STEP;
          end
        end
        ST_HALT_WAIT: begin
          if_id <= IF_ID_NOP;
          // A zero drain length still needs one edge to leave HALT_WAIT.
          if (drain <= 8'd1) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
            drain  <= '0;
          end else begin
            drain <= drain - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi)
      fetch_count <= '0;
    else if (fetch && (fetch_count != 16'hFFFF))
      fetch_count <= fetch_count + 16'd1;
  end

  assign pc_po          = pc;
  assign if_id_instr_po = if_id.instr;
  assign if_id_pc_po    = if_id.pc;
  assign if_id_valid_po = if_id.valid;
  assign halted_po      = halted;
  assign fetch_count_po = fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written halt/drain sequences,
// and randomized traffic against a behavioural fetch model.
module tb_fetch_ctrl;

  logic        clk_pi = 1'b0;
  logic        reset_pi = 1'b1;
  logic [31:0] pc_po;
  logic [31:0] instruction_pi;
  logic        stall_pi = 1'b0;
  logic        branch_taken_pi = 1'b0;
  logic [31:0] branch_target_pi = 32'h0;
  logic [31:0] if_id_instr_po;
  logic [31:0] if_id_pc_po;
  logic        if_id_valid_po;
  logic        halted_po;
  logic [15:0] fetch_count_po;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  assign instruction_pi = mem[pc_po[9:2]];

  always #5 clk_pi = ~clk_pi;

  fetch_ctrl dut (
    .clk_pi(clk_pi), .reset_pi(reset_pi), .pc_po(pc_po),
    .instruction_pi(instruction_pi), .stall_pi(stall_pi),
    .branch_taken_pi(branch_taken_pi), .branch_target_pi(branch_target_pi),
    .if_id_instr_po(if_id_instr_po), .if_id_pc_po(if_id_pc_po),
    .if_id_valid_po(if_id_valid_po), .halted_po(halted_po),
    .fetch_count_po(fetch_count_po)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic edge_with(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
    reset_pi = rst; stall_pi = stl; branch_taken_pi = br; branch_target_pi = tgt;
    @(posedge clk_pi);
    #1;
    reset_pi = 1'b0; stall_pi = 1'b0; branch_taken_pi = 1'b0;
  endtask

  function automatic logic [31:0] plain_word(input int idx);
    return {6'h08, 26'(idx)};
  endfunction

  localparam logic [31:0] HALT_W = 32'h28000000;

  typedef struct {
    logic        rst, stl, br;
    logic [31:0] tgt;
    logic [31:0] pc, ipc, iinstr;
    logic        valid, halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: the core is either fetching, waiting out a drain window
  // (drain_left > 0) or halted forever.
  logic [31:0] m_pc, m_ii, m_ip;
  logic        m_v, m_halted;
  int          m_cnt, drain_left;

  task automatic model_step(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
    logic [31:0] w;
    if (rst) begin
      m_pc = 0; m_ii = 0; m_ip = 0; m_v = 0; m_halted = 0; m_cnt = 0; drain_left = 0;
    end else if (m_halted) begin
    end else if (br) begin
      m_pc = tgt & ~32'h3; m_ii = 0; m_ip = 0; m_v = 0; drain_left = 0;
    end else if (stl) begin
    end else if (drain_left > 0) begin
      m_ii = 0; m_ip = 0; m_v = 0;
      drain_left--;
      if (drain_left == 0) m_halted = 1;
    end else begin
      w = mem[m_pc[9:2]];
      m_ii = w; m_ip = m_pc; m_v = 1;
      if (m_cnt < 65535) m_cnt++;
      if (w[31:26] == 6'h0A) drain_left = 3;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pc"}, pc_po, m_pc);
    check({tag, ".if_id_instr"}, if_id_instr_po, m_ii);
    check({tag, ".if_id_pc"}, if_id_pc_po, m_ip);
    check({tag, ".valid"}, 32'(if_id_valid_po), 32'(m_v));
    check({tag, ".halted"}, 32'(halted_po), 32'(m_halted));
    check({tag, ".count"}, 32'(fetch_count_po), 32'(m_cnt));
  endtask

  task automatic run_to_pc(input logic [31:0] stop_pc);
    for (int k = 0; k < 64 && pc_po != stop_pc; k++) edge_with(0, 0, 0, 0);
    check("run_to_pc", pc_po, stop_pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = plain_word(i);
    mem[0] = 32'h15080005;

    // Directed run / stall / branch-with-stall table.
    vecs.push_back('{1,0,0,0,  32'd0,  32'd0,  32'h0,        0,0,16'd0});
    vecs.push_back('{0,0,0,0,  32'd4,  32'd0,  32'h15080005, 1,0,16'd1});
    vecs.push_back('{0,0,0,0,  32'd8,  32'd4,  plain_word(1),1,0,16'd2});
    vecs.push_back('{0,1,0,0,  32'd8,  32'd4,  plain_word(1),1,0,16'd2});
    vecs.push_back('{0,1,0,0,  32'd8,  32'd4,  plain_word(1),1,0,16'd2});
    vecs.push_back('{0,0,0,0,  32'd12, 32'd8,  plain_word(2),1,0,16'd3});
    vecs.push_back('{0,0,0,0,  32'd16, 32'd12, plain_word(3),1,0,16'd4});
    vecs.push_back('{0,0,0,0,  32'd20, 32'd16, plain_word(4),1,0,16'd5});
    vecs.push_back('{0,0,0,0,  32'd24, 32'd20, plain_word(5),1,0,16'd6});
    vecs.push_back('{0,1,1,32'h7, 32'd4, 32'd0, 32'h0,        0,0,16'd6});
    vecs.push_back('{0,0,0,0,  32'd8,  32'd4,  plain_word(1),1,0,16'd7});

    @(negedge clk_pi);
    foreach (vecs[i]) begin
      edge_with(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d.pc", i), pc_po, vecs[i].pc);
      check($sformatf("vec%0d.if_id_pc", i), if_id_pc_po, vecs[i].ipc);
      check($sformatf("vec%0d.if_id_instr", i), if_id_instr_po, vecs[i].iinstr);
      check($sformatf("vec%0d.valid", i), 32'(if_id_valid_po), 32'(vecs[i].valid));
      check($sformatf("vec%0d.halted", i), 32'(halted_po), 32'(vecs[i].halted));
      check($sformatf("vec%0d.count", i), 32'(fetch_count_po), 32'(vecs[i].cnt));
    end

    // HALT at 24, full drain, then branch/stall ignored, then reset out.
    mem[6] = HALT_W;
    edge_with(1, 0, 0, 0);
    run_to_pc(24);
    edge_with(0, 0, 0, 0);
    check("halt.pc_hold", pc_po, 32'd24);
    check("halt.if_id_instr", if_id_instr_po, HALT_W);
    check("halt.valid", 32'(if_id_valid_po), 32'd1);
    check("halt.count", 32'(fetch_count_po), 32'd7);
    for (int k = 1; k <= 3; k++) begin
      edge_with(0, 0, 0, 0);
      check($sformatf("drain%0d.halted", k), 32'(halted_po), 32'(k == 3));
      check($sformatf("drain%0d.valid", k), 32'(if_id_valid_po), 32'd0);
      check($sformatf("drain%0d.pc", k), pc_po, 32'd24);
    end
    edge_with(0, 1, 1, 32'h40);
    check("halted.ignore_branch_pc", pc_po, 32'd24);
    check("halted.sticky", 32'(halted_po), 32'd1);
    edge_with(1, 0, 0, 0);
    check("halted.reset_pc", pc_po, 32'd0);
    check("halted.reset_halted", 32'(halted_po), 32'd0);
    check("halted.reset_count", 32'(fetch_count_po), 32'd0);

    // HALT at 24, stall holds the HALT word in IF/ID and the drain count.
    run_to_pc(24);
    edge_with(0, 0, 0, 0);
    edge_with(0, 1, 0, 0);
    edge_with(0, 1, 0, 0);
    check("hwstall.instr", if_id_instr_po, HALT_W);
    check("hwstall.valid", 32'(if_id_valid_po), 32'd1);
    for (int k = 1; k <= 3; k++) edge_with(0, 0, 0, 0);
    check("hwstall.halted", 32'(halted_po), 32'd1);

    // HALT at 40, branch two cycles later rescues the core.
    mem[6] = plain_word(6);
    mem[10] = HALT_W;
    edge_with(1, 0, 0, 0);
    run_to_pc(40);
    edge_with(0, 0, 0, 0);
    edge_with(0, 0, 0, 0);
    edge_with(0, 0, 1, 32'h4);
    check("rescue.pc", pc_po, 32'd4);
    check("rescue.halted", 32'(halted_po), 32'd0);
    check("rescue.valid", 32'(if_id_valid_po), 32'd0);
    for (int k = 0; k < 4; k++) edge_with(0, 0, 0, 0);
    check("rescue.resume_pc", pc_po, 32'd20);
    check("rescue.never_halted", 32'(halted_po), 32'd0);

    // Reset during HALT_WAIT.
    run_to_pc(40);
    edge_with(0, 0, 0, 0);
    edge_with(1, 0, 0, 0);
    check("hwreset.pc", pc_po, 32'd0);
    check("hwreset.valid", 32'(if_id_valid_po), 32'd0);
    check("hwreset.count", 32'(fetch_count_po), 32'd0);
    edge_with(0, 0, 0, 0);
    edge_with(0, 0, 0, 0);
    edge_with(0, 0, 0, 0);
    check("hwreset.refetch", pc_po, 32'd12);

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? (HALT_W | 32'($urandom_range(0, 32'h3FFFFFF)))
                                            : $urandom;
    model_step(1, 0, 0, 0);
    edge_with(1, 0, 0, 0);
    compare_model("rnd_reset");
    for (int c = 0; c < 3000; c++) begin
      logic r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = $urandom & 32'h3FF;
      model_step(r, s, b, t);
      edge_with(r, s, b, t);
      compare_model($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage pipelined core.
- Owns the PC and drives the combinational instruction memory (pc_po -> memory, instruction_pi <- memory).
- Loads the IF/ID pipeline register; handles hazard stalls, taken-branch redirect/squash and HALT detection/drain.
- Sits between insMem and the decode stage; driven by the hazard unit and the branch-resolution logic.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- HALT_OPC, 6'h0A, opcode (instruction[31:26]) identifying HALT.
- DRAIN_CYCLES, 3, non-stalled cycles to wait after HALT for older in-flight branches to resolve.

Ports:
- clk_pi  in  1  clock; all state updates on rising edge.
- reset_pi  in  1  synchronous, active-high reset.
- pc_po  out  32  current fetch address to instruction memory.
- instruction_pi  in  32  instruction word returned for pc_po, same cycle.
- stall_pi  in  1  hazard stall: hold PC and IF/ID.
- branch_taken_pi  in  1  taken branch resolved this cycle.
- branch_target_pi  in  32  redirect address, valid with branch_taken_pi.
- if_id_instr_po  out  32  IF/ID instruction register.
- if_id_pc_po  out  32  IF/ID PC register.
- if_id_valid_po  out  1  IF/ID holds a real (non-squashed) instruction.
- halted_po  out  1  processor halted, sticky.
- fetch_count_po  out  16  valid instructions loaded into IF/ID, saturating.

Behaviour:
- Reset (reset_pi=1 at edge, any state, including mid-drain):
  - pc=RESET_PC; if_id_instr=32'h0 (NOP); if_id_pc=0; if_id_valid=0; halted_po=0; fetch_count=0; drain counter=0; state RUN.
- Fetch latency: instruction_pi for pc_po appears on if_id_instr_po one edge later.
- FSM states: RUN, HALT_WAIT, HALTED.
- Priority each edge: reset > branch_taken_pi > stall_pi > normal.
- RUN, normal:
  - if_id <= {instruction_pi, pc_po}, valid=1, fetch_count+1.
  - If opcode != HALT_OPC: pc <= pc+4, wrapping modulo 2^32.
  - If opcode == HALT_OPC: pc holds, counter <= DRAIN_CYCLES, go HALT_WAIT.
- RUN, stall (no branch): pc, if_id and counter hold.
- branch_taken_pi in RUN or HALT_WAIT:
  - pc <= {branch_target_pi[31:2],2'b00}.
  - if_id_instr <= 0, valid <= 0 (squash), if_id_pc <= 0, fetch_count unchanged.
  - State -> RUN.
  - Applies even if stall_pi=1 simultaneously.
- HALT_WAIT, no branch, no stall:
  - No fetch: pc holds; if_id <= NOP, valid=0.
  - counter decrements; when counter is 1 at the edge, go HALTED.
- HALT_WAIT, stall: everything holds, including the HALT word in IF/ID and the counter.
- HALTED:
  - halted_po=1; pc frozen; if_id NOP, valid=0.
  - stall_pi and branch_taken_pi ignored; exit only via reset.
- fetch_count saturates at 16'hFFFF.
- halted_po is registered; asserts on the edge entering HALTED.
- Unknown/zero instruction words are fetched normally (0 is NOP).

Decomposition:
- Shared package core_pkg holds:
  - OPC_HALT=6'h0A, NOP_WORD=32'h0, PC_STEP=4.
  - Opcode field bounds [31:26].
  - FSM state encoding for RUN/HALT_WAIT/HALTED.
- No sub-module: PC register, IF/ID register and FSM fit in one block.
- The saturating counter may be an inline always block.

Test Plan:
- Reset then run, memory returning 32'h15080005 at 0, non-HALT elsewhere -> pc_po 0,4,8,12 on successive edges; if_id_pc_po lags by one; fetch_count 1,2,3.
- stall_pi=1 for 2 cycles at pc=8 -> pc_po stays 8, IF/ID stays {instr@4, 4}, fetch_count unchanged; resumes at 12.
- branch_taken_pi=1, target 32'h4, same cycle stall_pi=1, at pc=24 -> next pc_po=4, if_id_valid=0, if_id_instr=0.
- 32'h28000000 fetched at pc=24, no stalls -> pc_po holds 24, HALT in IF/ID one cycle, halted_po=1 exactly 3 edges after HALT_WAIT entry.
- HALT at 40, branch_taken to 4 two cycles later -> back to RUN, pc_po=4, halted_po stays 0.
- reset_pi=1 during HALT_WAIT or HALTED -> next edge pc_po=RESET_PC, halted_po=0, valid=0, fetch_count=0.
